// File: rtl/filter_coef_ctrl.sv
// Coefficient shadow/active bank controller for the 5x5 luma filter.
// Host writes go to a shadow bank; a commit copies it to the active outputs on the next V-sync rise.
module filter_coef_ctrl #(
  parameter int COEF_WIDTH = 10,
  parameter int NUM_COEF   = 25,
  parameter int CENTER_IDX = 12,
  parameter int UNITY      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_vs,
  input  logic                           i_wr_valid,
  input  logic [4:0]                     i_wr_addr,
  input  logic [COEF_WIDTH-1:0]          i_wr_data,
  output logic                           o_wr_ready,
  input  logic                           i_load_default,
  input  logic                           i_commit,
  input  logic                           i_bypass,
  output logic [NUM_COEF*COEF_WIDTH-1:0] o_coef,
  output logic                           o_bypass,
  output logic                           o_pending,
  output logic                           o_update,
  output logic                           o_err
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_PEND} state_t;
  typedef logic [NUM_COEF-1:0][COEF_WIDTH-1:0] bank_t;

  localparam logic [4:0] ADDR_LIM = 5'(NUM_COEF);
  localparam logic [4:0] LAST_IDX = 5'(NUM_COEF - 1);
  localparam logic [4:0] CTR_IDX  = 5'(CENTER_IDX);

  function automatic bank_t ident_bank();
    bank_t b;
    b = '0;
    b[CENTER_IDX] = COEF_WIDTH'(UNITY);
    return b;
  endfunction

  localparam bank_t IDENT = ident_bank();

  state_t state_q, state_d;
  bank_t  shadow_q, shadow_d;
  bank_t  active_q, active_d;
  logic   bypass_q, bypass_d;
  logic   bp_latch_q, bp_latch_d;
  logic   [4:0] cnt_q, cnt_d;
  logic   vs_q;
  logic   update_q, update_d;
  logic   err_q, err_d;

  logic vs_rise;
  logic wr_fire;
  logic addr_ok;

  assign vs_rise = i_vs & ~vs_q;
  assign wr_fire = i_wr_valid & o_wr_ready;
  assign addr_ok = i_wr_addr < ADDR_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_load_default)   state_d = S_INIT;
        else if (i_commit)    state_d = S_PEND;
      end
      S_INIT: if (cnt_q == LAST_IDX) state_d = S_IDLE;
      S_PEND: if (vs_rise)           state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_wr_ready = (state_q == S_IDLE);
    o_pending  = (state_q == S_PEND);
  end

  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    bypass_d   = bypass_q;
    bp_latch_d = bp_latch_q;
    cnt_d      = cnt_q;
    update_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The write lands in the same edge as a commit, so the commit carries it.
        if (wr_fire) begin
          if (addr_ok) shadow_d[i_wr_addr] = i_wr_data;
          else         err_d = 1'b1;
        end
        if (i_load_default) begin
          cnt_d = '0;
          if (i_commit) err_d = 1'b1;
        end else if (i_commit) begin
          bp_latch_d = i_bypass;
        end
      end
      S_INIT: begin
        shadow_d[cnt_q] = (cnt_q == CTR_IDX) ? COEF_WIDTH'(UNITY) : '0;
        cnt_d = cnt_q + 5'd1;
        if (i_commit || i_load_default) err_d = 1'b1;
      end
      S_PEND: begin
        if (vs_rise) begin
          active_d = shadow_q;
          bypass_d = bp_latch_q;
          update_d = 1'b1;
        end
        if (i_commit || i_load_default) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= IDENT;
      active_q   <= IDENT;
      bypass_q   <= 1'b1;
      bp_latch_q <= 1'b0;
      cnt_q      <= '0;
      vs_q       <= 1'b0;
      update_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      bypass_q   <= bypass_d;
      bp_latch_q <= bp_latch_d;
      cnt_q      <= cnt_d;
      vs_q       <= i_vs;
      update_q   <= update_d;
      err_q      <= err_d;
    end
  end

  assign o_coef   = active_q;
  assign o_bypass = bypass_q;
  assign o_update = update_q;
  assign o_err    = err_q;

endmodule
